// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM and ALU decoder for a multicycle RISC-V datapath
module multicycle_control #(
    parameter int ALU_CTRL_W  = 3,
    parameter int SUPPORT_BNE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  zero,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic                  illegal_op,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam bit WIDE_ALU = (ALU_CTRL_W >= 4);

    // Plain 4-bit register so the unused codes 11-15 stay representable and recoverable.
    logic [3:0] state_q;
    logic [3:0] state_next;
    logic [3:0] out_state;

    logic       is_bne;
    logic       op_illegal;
    logic       alu_illegal;
    logic [1:0] alu_op;
    logic [3:0] alu_ctl;
    logic       branch;
    logic       pc_update;
    logic       ir_en;
    logic       mem_en;
    logic       reg_en;

    assign is_bne = (SUPPORT_BNE != 0) && (funct3 == 3'b001);

    always_comb begin
        op_illegal = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL: op_illegal = 1'b0;
            OP_B:    op_illegal = !((funct3 == 3'b000) || is_bne);
            default: op_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_q)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (op_illegal) begin
                    state_next = S_FETCH;
                end else begin
                    case (op)
                        OP_LW, OP_SW: state_next = S_MEMADR;
                        OP_R:         state_next = S_EXECR;
                        OP_I:         state_next = S_EXECI;
                        OP_B:         state_next = S_BRANCH;
                        OP_JAL:       state_next = S_JAL;
                        default:      state_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:  state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: state_next = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: state_next = S_ALUWB;
            default:   state_next = S_FETCH;
        endcase
    end

    // During reset the outputs present the FETCH decode; write strobes are gated below.
    assign out_state = reset ? S_FETCH : state_q;

    always_comb begin
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        branch     = 1'b0;
        pc_update  = 1'b0;
        ir_en      = 1'b0;
        mem_en     = 1'b0;
        reg_en     = 1'b0;
        illegal_op = 1'b0;
        case (out_state)
            S_FETCH: begin
                ir_en      = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            S_DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b01;
                illegal_op = op_illegal;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_en  = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_en     = 1'b1;
            end
            S_EXECR: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                illegal_op = alu_illegal;
            end
            S_EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
                illegal_op = alu_illegal;
            end
            S_ALUWB: reg_en = 1'b1;
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_ctl     = 4'd0;
        alu_illegal = 1'b0;
        case (alu_op)
            2'b00: alu_ctl = 4'd0;
            2'b01: alu_ctl = 4'd1;
            default: begin
                case (funct3)
                    3'b000: alu_ctl = (op[5] && funct7_5) ? 4'd1 : 4'd0;
                    3'b010: alu_ctl = 4'd5;
                    3'b110: alu_ctl = 4'd3;
                    3'b111: alu_ctl = 4'd2;
                    3'b100: begin
                        alu_ctl     = WIDE_ALU ? 4'd4 : 4'd0;
                        alu_illegal = !WIDE_ALU;
                    end
                    3'b001: begin
                        alu_ctl     = WIDE_ALU ? 4'd6 : 4'd0;
                        alu_illegal = !WIDE_ALU;
                    end
                    3'b101: begin
                        alu_ctl     = WIDE_ALU ? (funct7_5 ? 4'd8 : 4'd7) : 4'd0;
                        alu_illegal = !WIDE_ALU;
                    end
                    default: alu_ctl = 4'd0;
                endcase
            end
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_B:    imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign alu_control = alu_ctl[ALU_CTRL_W-1:0];
    assign pc_write    = !reset && (pc_update || (branch && (zero ^ is_bne)));
    assign ir_write    = !reset && ir_en;
    assign mem_write   = !reset && mem_en;
    assign reg_write   = !reset && reg_en;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0000011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;

    logic       a_pc_write, a_adr_src, a_mem_write, a_ir_write, a_reg_write, a_illegal_op;
    logic [1:0] a_result_src, a_alu_src_a, a_alu_src_b, a_imm_src;
    logic [2:0] a_alu_control;
    logic [3:0] a_state;

    logic       w_pc_write, w_adr_src, w_mem_write, w_ir_write, w_reg_write, w_illegal_op;
    logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b, w_imm_src;
    logic [3:0] w_alu_control;
    logic [3:0] w_state;

    int checks = 0;
    int failures = 0;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    multicycle_control #(.ALU_CTRL_W(3), .SUPPORT_BNE(1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
        .pc_write(a_pc_write), .adr_src(a_adr_src), .mem_write(a_mem_write),
        .ir_write(a_ir_write), .reg_write(a_reg_write), .illegal_op(a_illegal_op),
        .result_src(a_result_src), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
        .imm_src(a_imm_src), .alu_control(a_alu_control), .state(a_state)
    );

    multicycle_control #(.ALU_CTRL_W(4), .SUPPORT_BNE(0)) dut_wide (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
        .pc_write(w_pc_write), .adr_src(w_adr_src), .mem_write(w_mem_write),
        .ir_write(w_ir_write), .reg_write(w_reg_write), .illegal_op(w_illegal_op),
        .result_src(w_result_src), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b),
        .imm_src(w_imm_src), .alu_control(w_alu_control), .state(w_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [6:0] o, input logic [2:0] f3, input logic f75, input logic z);
        reset = 1'b1;
        op = o;
        funct3 = f3;
        funct7_5 = f75;
        zero = z;
        cyc();
        reset = 1'b0;
        #1;
    endtask

    logic [2:0] rf3  [9] = '{3'd0, 3'd0, 3'd2, 3'd6, 3'd7, 3'd4, 3'd1, 3'd5, 3'd5};
    logic       rf75 [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] rexp [9] = '{4'd0, 4'd1, 4'd5, 4'd3, 4'd2, 4'd4, 4'd6, 4'd7, 4'd8};

    logic [2:0] bf3  [5] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd4};
    logic       bz   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       bpcw [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       bila [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       bilw [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        // Reset with outputs forced to FETCH decode, write strobes low
        cyc();
        check("rst_state", a_state, 4'd0);
        check("rst_pc_write", a_pc_write, 1'b0);
        check("rst_ir_write", a_ir_write, 1'b0);
        check("rst_alu_src_b", a_alu_src_b, 2'b10);
        reset = 1'b0;
        #1;
        check("fetch_ir_write", a_ir_write, 1'b1);
        check("fetch_pc_write", a_pc_write, 1'b1);
        check("fetch_result_src", a_result_src, 2'b10);

        // lw: 0,1,2,3,4,0
        cyc();
        check("lw_decode", a_state, 4'd1);
        check("lw_dec_srcb", a_alu_src_b, 2'b01);
        check("lw_dec_regw", a_reg_write, 1'b0);
        cyc();
        check("lw_memadr", a_state, 4'd2);
        check("lw_memadr_srca", a_alu_src_a, 2'b10);
        cyc();
        check("lw_memread", a_state, 4'd3);
        check("lw_memread_adr", a_adr_src, 1'b1);
        check("lw_memread_regw", a_reg_write, 1'b0);
        cyc();
        check("lw_memwb", a_state, 4'd4);
        check("lw_memwb_regw", a_reg_write, 1'b1);
        check("lw_memwb_res", a_result_src, 2'b01);
        cyc();
        check("lw_done", a_state, 4'd0);

        // sw, then reset mid-MEMWRITE
        start(OP_SW, 3'd2, 1'b0, 1'b0);
        check("sw_imm", a_imm_src, 2'b01);
        cyc();
        cyc();
        cyc();
        check("sw_memwrite", a_state, 4'd5);
        check("sw_memw", a_mem_write, 1'b1);
        check("sw_adr", a_adr_src, 1'b1);
        reset = 1'b1;
        #1;
        check("sw_rst_memw", a_mem_write, 1'b0);
        check("sw_rst_srcb", a_alu_src_b, 2'b10);
        cyc();
        check("sw_rst_state", a_state, 4'd0);
        reset = 1'b0;

        // R-type ALU decode in EXECR for both widths
        for (int i = 0; i < 9; i++) begin
            automatic logic ill3 = (rf3[i] == 3'd4) || (rf3[i] == 3'd1) || (rf3[i] == 3'd5);
            start(OP_R, rf3[i], rf75[i], 1'b0);
            cyc();
            cyc();
            check($sformatf("r%0d_state", i), a_state, 4'd6);
            check($sformatf("r%0d_wide_ctl", i), w_alu_control, rexp[i]);
            check($sformatf("r%0d_wide_ill", i), w_illegal_op, 1'b0);
            check($sformatf("r%0d_ctl", i), a_alu_control, ill3 ? 3'd0 : rexp[i][2:0]);
            check($sformatf("r%0d_ill", i), a_illegal_op, ill3);
        end
        cyc();
        check("r_aluwb", a_state, 4'd8);
        check("r_aluwb_regw", a_reg_write, 1'b1);
        cyc();
        check("r_done", a_state, 4'd0);

        // addi with funct7_5 set stays add
        start(OP_I, 3'd0, 1'b1, 1'b0);
        cyc();
        cyc();
        check("i_state", a_state, 4'd7);
        check("i_ctl", a_alu_control, 3'd0);
        check("i_srcb", a_alu_src_b, 2'b01);

        // branches: beq/bne on both instances, blt illegal
        for (int i = 0; i < 5; i++) begin
            start(OP_B, bf3[i], 1'b0, bz[i]);
            cyc();
            check($sformatf("b%0d_imm", i), a_imm_src, 2'b10);
            check($sformatf("b%0d_ill", i), a_illegal_op, bila[i]);
            check($sformatf("b%0d_wide_ill", i), w_illegal_op, bilw[i]);
            check($sformatf("b%0d_dec_pcw", i), a_pc_write, 1'b0);
            cyc();
            check($sformatf("b%0d_state", i), a_state, bila[i] ? 4'd0 : 4'd9);
            check($sformatf("b%0d_wide_state", i), w_state, bilw[i] ? 4'd0 : 4'd9);
            if (!bila[i]) begin
                check($sformatf("b%0d_pcw", i), a_pc_write, bpcw[i]);
                check($sformatf("b%0d_ctl", i), a_alu_control, 3'd1);
                cyc();
                check($sformatf("b%0d_done", i), a_state, 4'd0);
            end
        end

        // jal
        start(OP_JAL, 3'd0, 1'b0, 1'b0);
        cyc();
        check("jal_imm", a_imm_src, 2'b11);
        cyc();
        check("jal_state", a_state, 4'd10);
        check("jal_pcw", a_pc_write, 1'b1);
        check("jal_srca", a_alu_src_a, 2'b01);
        check("jal_srcb", a_alu_src_b, 2'b10);
        cyc();
        check("jal_aluwb", a_state, 4'd8);
        cyc();
        check("jal_done", a_state, 4'd0);

        // unknown opcode
        start(7'b1111111, 3'd0, 1'b0, 1'b0);
        cyc();
        check("bad_ill", a_illegal_op, 1'b1);
        check("bad_writes", {a_pc_write, a_ir_write, a_mem_write, a_reg_write}, 4'b0000);
        cyc();
        check("bad_state", a_state, 4'd0);
        check("bad_ill_clear", a_illegal_op, 1'b0);

        // spare state code recovers to FETCH
        force dut.state_q = 4'd12;
        #1;
        check("spare_state", a_state, 4'd12);
        check("spare_next", dut.state_next, 4'd0);
        check("spare_writes", {a_pc_write, a_ir_write, a_mem_write, a_reg_write}, 4'b0000);
        release dut.state_q;
        reset = 1'b1;
        cyc();
        check("spare_rst_state", a_state, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter ALU_CTRL_W, default 3, alu_control width; legal values 3 or 4 (4 enables xor/sll/srl/sra).
REQ-002 SHALL have parameter SUPPORT_BNE, default 1; 1 enables bne (funct3=001) branches.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have inputs op[6:0], funct3[2:0], funct7_5 (1), zero (1, ALU result==0), all sampled from the instruction register/ALU.
REQ-006 SHALL have 1-bit outputs pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op.
REQ-007 SHALL have 2-bit outputs result_src, alu_src_a, alu_src_b, imm_src; output alu_control[ALU_CTRL_W-1:0]; output state[3:0] for debug.

Function
REQ-008 SHALL implement a Moore FSM with encodings FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10; codes 11-15 SHALL return to FETCH next cycle.
REQ-009 Transitions: FETCH->DECODE; DECODE by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, else FETCH.
REQ-010 Transitions: MEMADR->MEMREAD if op[5]=0 else MEMWRITE; MEMREAD->MEMWB; EXECR/EXECI/JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BRANCH->FETCH.
REQ-011 Per-state outputs (unlisted = 0): FETCH ir_write=1, alu_src_b=10, result_src=10, pc_update=1; DECODE alu_src_a=01, alu_src_b=01.
REQ-012 MEMADR alu_src_a=10, alu_src_b=01; MEMREAD/MEMWRITE adr_src=1, MEMWRITE mem_write=1; MEMWB result_src=01, reg_write=1; ALUWB reg_write=1.
REQ-013 EXECR alu_src_a=10, alu_op=10; EXECI alu_src_a=10, alu_src_b=01, alu_op=10; BRANCH alu_src_a=10, alu_op=01, branch=1; JAL alu_src_a=01, alu_src_b=10, pc_update=1.
REQ-014 pc_write SHALL equal pc_update OR (branch AND (zero XOR bne)), bne = SUPPORT_BNE AND funct3==001.
REQ-015 imm_src SHALL decode combinationally from op: 0100011->01, 1100011->10, 1101111->11, else 00.
REQ-016 alu_control: alu_op 00->add(0), 01->sub(1); alu_op 10 by funct3: 000 sub(1) if op[5]&funct7_5 else add(0); 010 slt(5); 110 or(3); 111 and(2).
REQ-017 With ALU_CTRL_W=4 additionally: 100 xor(4), 001 sll(6), 101 srl(7) or sra(8) when funct7_5=1; with ALU_CTRL_W=3 these funct3 SHALL yield 0 and raise illegal_op in EXECR/EXECI.
REQ-018 illegal_op SHALL be 1 for exactly one cycle in DECODE for unknown op, or branch with funct3 not 000 (nor 001 when SUPPORT_BNE=1); FSM then returns to FETCH without any write.
REQ-019 Latency: lw 5 cycles, sw/R/I/jal 4, branch 3, illegal 2 (FETCH to next FETCH).
REQ-020 state output SHALL equal current state register.

Reset
REQ-021 reset high at a rising edge SHALL load FETCH regardless of current state, including mid-instruction.
REQ-022 While reset is high, pc_write, ir_write, mem_write, reg_write SHALL be forced 0; other outputs follow FETCH values.
REQ-023 After reset release, first cycle SHALL be FETCH with ir_write=1, pc_write=1.

Verification
REQ-024 lw (op=0000011) from reset -> states 0,1,2,3,4,0; reg_write=1 only in MEMWB; adr_src=1 in MEMREAD.
REQ-025 beq, zero=1 -> pc_write=1 in BRANCH, alu_control=1; bne (funct3=001), zero=1 -> pc_write=0; zero=0 -> pc_write=1.
REQ-026 R-type sub (funct3=000, funct7_5=1) -> alu_control=1 in EXECR; ALU_CTRL_W=4 sra (funct3=101, funct7_5=1) -> 8; ALU_CTRL_W=3 xor -> illegal_op=1, alu_control=0.
REQ-027 op=1111111 -> illegal_op=1 one cycle in DECODE, next state FETCH, no write enables asserted.
REQ-028 reset asserted in MEMWRITE -> mem_write=0 that cycle, state=0 next cycle; forced state code 12 -> FETCH next edge.
